gb_oam_scan: RTL and testbench

//  PPU mode-2 OAM scanner: the reader on the PPU side of the OAM/DMA block's object port.

---
 rtl/gb_oam_pkg.sv | 45 ++++
 rtl/gb_oam_scan_if.sv | 32 +++
 rtl/gb_oam_line_buffer.sv | 42 ++++
 rtl/gb_oam_scan.sv | 154 +++++++++++++++
 tb/tb_gb_oam_scan.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gb_oam_pkg.sv
`default_nettype none
// ============================================================================
// Package : gb_oam_pkg
// Brief   : Shared OAM types, scan constants and Y-range hit helper.
// Rev     : 1.0  initial release
// ============================================================================
package gb_oam_pkg;

    localparam int OAM_NUM_OBJS     = 40;
    localparam int OAM_MAX_PER_LINE = 10;
    localparam int OAM_Y_OFFSET     = 16;

    typedef struct packed {
        logic [7:0] y_pos;
        logic [7:0] x_pos;
        logic [7:0] tile;
        logic [7:0] flags;
    } oam_obj_t;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_FETCH = 2'd1,
        SCAN_EVAL  = 2'd2
    } oam_scan_state_t;

    typedef struct packed {
        oam_obj_t   obj;
        logic [5:0] oam_idx;
    } oam_sel_t;

    // 9-bit compare so ly+16 and y+height never wrap
    function automatic logic oam_y_hit(input logic [7:0] ly,
                                       input logic [7:0] y_pos,
                                       input logic       tall);
        logic [8:0] t;
        logic [8:0] y;
        logic [8:0] h;
        t = {1'b0, ly} + 9'(OAM_Y_OFFSET);
        y = {1'b0, y_pos};
        h = tall ? 9'd16 : 9'd8;
        return (t >= y) && (t < y + h);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_oam_scan_if.sv
`default_nettype none
// ============================================================================
// Interface : gb_oam_scan_if
// Brief     : OAM object port and selected-object read port of the scanner.
// Rev       : 1.0  initial release
// ============================================================================
interface gb_oam_scan_if;
    import gb_oam_pkg::*;

    logic [6:0] oam_index_o;
    oam_obj_t   obj_i;
    logic [3:0] sel_rd_idx;
    oam_obj_t   sel_obj_o;
    logic [5:0] sel_oam_idx_o;

    modport master (
        output oam_index_o,
        input  obj_i,
        input  sel_rd_idx,
        output sel_obj_o,
        output sel_oam_idx_o
    );

    modport slave (
        input  oam_index_o,
        output obj_i,
        output sel_rd_idx,
        input  sel_obj_o,
        input  sel_oam_idx_o
    );
endinterface
`default_nettype wire

// File: rtl/gb_oam_line_buffer.sv
`default_nettype none
// ============================================================================
// Module : gb_oam_line_buffer
// Brief  : Register file of selected objects; one write, one combinational read.
// Rev    : 1.0  initial release
// ============================================================================
module gb_oam_line_buffer
    import gb_oam_pkg::*;
#(
    parameter int DEPTH = OAM_MAX_PER_LINE
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       wr_en_i,
    input  wire logic [3:0] wr_idx_i,
    input  oam_sel_t        wr_data_i,
    input  wire logic [3:0] rd_idx_i,
    output oam_sel_t        rd_data_o
);

    oam_sel_t mem_q [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q[g] <= '0;
            end else if (wr_en_i && (wr_idx_i == 4'(g))) begin
                mem_q[g] <= wr_data_i;
            end
        end
    end

    // Out-of-range slots read as zero rather than aliasing a real entry
    always_comb begin
        rd_data_o = '0;
        if (rd_idx_i < 4'(DEPTH)) begin
            rd_data_o = mem_q[rd_idx_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/gb_oam_scan.sv
`default_nettype none
// ============================================================================
// Module : gb_oam_scan
// Brief  : PPU mode-2 OAM scanner; selects up to 10 objects on line LY.
// Config : OAM_SCAN_OVERFLOW_EN adds the sticky scan_overflow output.
// Rev    : 1.0  initial release
// ============================================================================
module gb_oam_scan
    import gb_oam_pkg::*;
#(
    parameter int NUM_OBJS     = OAM_NUM_OBJS,
    parameter int MAX_PER_LINE = OAM_MAX_PER_LINE
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       scan_start,
    input  wire logic [7:0] ly,
    input  wire logic       obj_size_16,
    input  wire logic       dma_active,
    output logic            scan_busy,
    output logic            scan_done,
    output logic [3:0]      sel_count,
`ifdef OAM_SCAN_OVERFLOW_EN
    output logic            scan_overflow,
`endif
    gb_oam_scan_if.master   bus
);

    oam_scan_state_t state_q, state_d;
    logic [5:0]      index_q, index_d;
    logic [3:0]      count_q, count_d;
    logic [7:0]      ly_q, ly_d;
    logic            size16_q, size16_d;
    oam_obj_t        obj_q, obj_d;
    logic            inv_q, inv_d;
    logic            done_q, done_d;
    logic            w_hit;
    logic            w_wr_en;
    oam_sel_t        w_wr_data;
    oam_sel_t        w_rd_data;
`ifdef OAM_SCAN_OVERFLOW_EN
    logic            ovf_q, ovf_d;
`endif

    assign w_hit     = oam_y_hit(ly_q, obj_q.y_pos, size16_q) && !inv_q;
    assign w_wr_data = {obj_q, index_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SCAN_IDLE;
            index_q  <= '0;
            count_q  <= '0;
            ly_q     <= '0;
            size16_q <= 1'b0;
            obj_q    <= '0;
            inv_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef OAM_SCAN_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            count_q  <= count_d;
            ly_q     <= ly_d;
            size16_q <= size16_d;
            obj_q    <= obj_d;
            inv_q    <= inv_d;
            done_q   <= done_d;
`ifdef OAM_SCAN_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        count_d  = count_q;
        ly_d     = ly_q;
        size16_d = size16_q;
        obj_d    = obj_q;
        inv_d    = inv_q;
        done_d   = 1'b0;
        w_wr_en  = 1'b0;
`ifdef OAM_SCAN_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        // A start pulse wins in every state, so an aborted scan never signals done
        if (scan_start) begin
            state_d  = SCAN_FETCH;
            index_d  = '0;
            count_d  = '0;
            ly_d     = ly;
            size16_d = obj_size_16;
`ifdef OAM_SCAN_OVERFLOW_EN
            ovf_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                SCAN_FETCH: begin
                    obj_d   = bus.obj_i;
                    inv_d   = dma_active;
                    state_d = SCAN_EVAL;
                end
                SCAN_EVAL: begin
                    if (w_hit) begin
                        if (count_q < 4'(MAX_PER_LINE)) begin
                            w_wr_en = 1'b1;
                            count_d = count_q + 4'd1;
                        end else begin
`ifdef OAM_SCAN_OVERFLOW_EN
                            ovf_d = 1'b1;
`endif
                        end
                    end
                    if (index_q == 6'(NUM_OBJS - 1)) begin
                        state_d = SCAN_IDLE;
                        index_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SCAN_FETCH;
                        index_d = index_q + 6'd1;
                    end
                end
                default: state_d = SCAN_IDLE;
            endcase
        end
    end

    gb_oam_line_buffer #(
        .DEPTH (MAX_PER_LINE)
    ) u_line_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (w_wr_en),
        .wr_idx_i  (count_q),
        .wr_data_i (w_wr_data),
        .rd_idx_i  (bus.sel_rd_idx),
        .rd_data_o (w_rd_data)
    );

    assign scan_busy         = (state_q != SCAN_IDLE);
    assign scan_done         = done_q;
    assign sel_count         = count_q;
    assign bus.oam_index_o   = {1'b0, index_q};
    assign bus.sel_obj_o     = w_rd_data.obj;
    assign bus.sel_oam_idx_o = w_rd_data.oam_idx;
`ifdef OAM_SCAN_OVERFLOW_EN
    assign scan_overflow     = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gb_oam_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_gb_oam_scan
// Brief  : Self-checking bench for gb_oam_scan against a list-based OAM model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gb_oam_scan;
    import gb_oam_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_start = 1'b0;
    logic [7:0] ly = 8'd0;
    logic       obj_size_16 = 1'b0;
    logic       dma_active;
    logic       scan_busy;
    logic       scan_done;
    logic [3:0] sel_count;
`ifdef OAM_SCAN_OVERFLOW_EN
    logic       scan_overflow;
`endif

    gb_oam_scan_if u_bus ();

    gb_oam_scan u_dut (
        .clk           (clk),
        .reset         (reset),
        .scan_start    (scan_start),
        .ly            (ly),
        .obj_size_16   (obj_size_16),
        .dma_active    (dma_active),
        .scan_busy     (scan_busy),
        .scan_done     (scan_done),
        .sel_count     (sel_count),
`ifdef OAM_SCAN_OVERFLOW_EN
        .scan_overflow (scan_overflow),
`endif
        .bus           (u_bus)
    );

    always #5 clk = ~clk;

    oam_obj_t    oam_mem [40];
    logic [39:0] dma_mask = '0;
    int          total = 0;
    int          bad = 0;
    int          exp_q[$];
    logic        exp_ovf;

    // OAM memory and DMA window seen through the object port
    always_comb begin
        u_bus.obj_i = '0;
        dma_active  = 1'b0;
        if (u_bus.oam_index_o < 7'd40) begin
            u_bus.obj_i = oam_mem[u_bus.oam_index_o[5:0]];
            dma_active  = dma_mask[u_bus.oam_index_o[5:0]];
        end
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: OAM-order list of hit indices, truncated at ten entries
    task automatic build_expected(input logic [7:0] l, input logic s16);
        int t;
        int h;
        exp_q.delete();
        exp_ovf = 1'b0;
        t = int'(l) + 16;
        h = s16 ? 16 : 8;
        for (int i = 0; i < 40; i++) begin
            if (!dma_mask[i] && t >= int'(oam_mem[i].y_pos) && t < int'(oam_mem[i].y_pos) + h) begin
                if (exp_q.size() < 10) exp_q.push_back(i);
                else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 40; i++) oam_mem[i] = '0;
        dma_mask = '0;
    endtask

    // Returns at the falling edge of cycle 1; ly/size are scrambled to prove latching
    task automatic start_pulse(input logic [7:0] l, input logic s16);
        @(negedge clk);
        ly          = l;
        obj_size_16 = s16;
        scan_start  = 1'b1;
        @(negedge clk);
        scan_start  = 1'b0;
        ly          = 8'($urandom);
        obj_size_16 = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int c;
        int busy_cnt;
        c = 1;
        busy_cnt = 0;
        while (!scan_done && c < 300) begin
            if (scan_busy) busy_cnt++;
            @(negedge clk);
            c++;
        end
        chk_val({tag, "_done_cycle"}, 64'(c), 64'd81);
        chk_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd80);
        chk_val({tag, "_busy_at_done"}, 64'(scan_busy), 64'd0);
        @(negedge clk);
        chk_val({tag, "_done_pulse"}, 64'(scan_done), 64'd0);
    endtask

    task automatic check_buffer(input string tag);
        chk_val({tag, "_sel_count"}, 64'(sel_count), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            u_bus.sel_rd_idx = 4'(k);
            #1;
            chk_val({tag, "_slot_obj"}, 64'(u_bus.sel_obj_o), 64'(oam_mem[exp_q[k]]));
            chk_val({tag, "_slot_idx"}, 64'(u_bus.sel_oam_idx_o), 64'(exp_q[k]));
        end
`ifdef OAM_SCAN_OVERFLOW_EN
        chk_val({tag, "_overflow"}, 64'(scan_overflow), 64'(exp_ovf));
`endif
    endtask

    task automatic do_scan(input string tag, input logic [7:0] l, input logic s16);
        build_expected(l, s16);
        start_pulse(l, s16);
        wait_done(tag);
        check_buffer(tag);
    endtask

    initial begin
        logic [63:0] rnd;
        int          n_done;
        int          v;
        logic [7:0]  rl;
        logic        rs;

        u_bus.sel_rd_idx = 4'd0;
        clear_oam();
        repeat (3) @(negedge clk);
        chk_val("rst_busy", 64'(scan_busy), 64'd0);
        chk_val("rst_done", 64'(scan_done), 64'd0);
        chk_val("rst_count", 64'(sel_count), 64'd0);
        chk_val("rst_index", 64'(u_bus.oam_index_o), 64'd0);
        chk_val("rst_slot0", 64'({u_bus.sel_obj_o, u_bus.sel_oam_idx_o}), 64'd0);
`ifdef OAM_SCAN_OVERFLOW_EN
        chk_val("rst_overflow", 64'(scan_overflow), 64'd0);
`endif
        reset = 1'b1;

        // Single hit at OAM#3 with X=0
        clear_oam();
        oam_mem[3] = '{y_pos: 8'd16, x_pos: 8'd0, tile: 8'h5A, flags: 8'h80};
        do_scan("t1", 8'd0, 1'b0);

        // Height boundary: y=8 misses at 8 px, hits at 16 px
        clear_oam();
        oam_mem[5] = '{y_pos: 8'd8, x_pos: 8'd33, tile: 8'h11, flags: 8'h20};
        do_scan("t2a", 8'd0, 1'b0);
        do_scan("t2b", 8'd0, 1'b1);

        // Twelve hits: only the first ten in OAM order are kept
        clear_oam();
        for (int i = 0; i < 12; i++) oam_mem[i] = '{y_pos: 8'd20, x_pos: 8'(i * 7), tile: 8'(i), flags: 8'(i + 64)};
        do_scan("t3", 8'd10, 1'b0);

        // DMA masks every entry; scan length unchanged
        clear_oam();
        for (int i = 0; i < 40; i++) oam_mem[i] = '{y_pos: 8'd16, x_pos: 8'(i), tile: 8'(i), flags: 8'd0};
        dma_mask = '1;
        do_scan("t4", 8'd0, 1'b0);

        // Restart at cycle 30 of a scan
        clear_oam();
        for (int i = 0; i < 40; i++) oam_mem[i] = '{y_pos: 8'(16 + (i % 9)), x_pos: 8'(i), tile: 8'(3 * i), flags: 8'(i)};
        start_pulse(8'd2, 1'b0);
        repeat (28) @(negedge clk);
        build_expected(8'd5, 1'b1);
        start_pulse(8'd5, 1'b1);
        chk_val("t5_index_restart", 64'(u_bus.oam_index_o), 64'd0);
        wait_done("t5");
        check_buffer("t5");

        // Asynchronous reset mid-scan
        clear_oam();
        for (int i = 0; i < 12; i++) oam_mem[i] = '{y_pos: 8'd20, x_pos: 8'd1, tile: 8'd2, flags: 8'd3};
        start_pulse(8'd10, 1'b0);
        repeat (39) @(negedge clk);
        reset = 1'b0;
        #1;
        u_bus.sel_rd_idx = 4'd0;
        #1;
        chk_val("t6_busy", 64'(scan_busy), 64'd0);
        chk_val("t6_count", 64'(sel_count), 64'd0);
        chk_val("t6_index", 64'(u_bus.oam_index_o), 64'd0);
        chk_val("t6_slot0", 64'({u_bus.sel_obj_o, u_bus.sel_oam_idx_o}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n_done = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (scan_done || scan_busy) n_done++;
        end
        chk_val("t6_no_activity", 64'(n_done), 64'd0);

        // Randomised scans clustered around the active Y window
        for (int it = 0; it < 16; it++) begin
            rl = 8'($urandom);
            rs = 1'($urandom);
            clear_oam();
            for (int i = 0; i < 40; i++) begin
                v = int'(rl) + 16 - int'($urandom_range(0, 24));
                if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 255));
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                oam_mem[i] = '{y_pos: 8'(v), x_pos: 8'($urandom), tile: 8'($urandom), flags: 8'($urandom)};
            end
            if ($urandom_range(0, 3) == 0) begin
                rnd = {32'($urandom), 32'($urandom)};
                dma_mask = rnd[39:0];
            end
            do_scan($sformatf("rnd%0d", it), rl, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
